rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4_pkg.sv | 18 +
 rtl/rr_arb4_if.sv | 33 +++
 rtl/rr_arb4_pick4.sv | 32 +++
 rtl/rr_arb4.sv | 137 +++++++++++++
 tb/tb_rr_arb4.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter (rr_arb4).
package arb4_pkg;

  // Number of requesters and width of a requester index.
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  // The last-served pointer resets to 3, so requester 0 is searched first after reset.
  localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

  // Arbiter control states. GAP is the single forced zero cycle between grants.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage : arb4_pkg

// File: rtl/rr_arb4_if.sv
// Request/grant bundle for rr_arb4.
// Handshake: a grant is presented while grant_valid=1 with a one-hot Y. Y and
// grant_valid stay stable until a rising edge sees grant_valid && grant_ready,
// which is the accept. grant_ready is ignored while grant_valid=0. timeout is a
// one-cycle pulse reporting that a grant was abandoned without an accept.
interface rr_arb4_if;
  import arb4_pkg::*;

  logic [N_REQ-1:0] req;
  logic             grant_ready;
  logic [N_REQ-1:0] Y;
  logic             grant_valid;
  logic             timeout;

  // Arbiter side: sees requests and ready, drives the grant.
  modport master (
    input  req,
    input  grant_ready,
    output Y,
    output grant_valid,
    output timeout
  );

  // Requester/downstream side.
  modport slave (
    output req,
    output grant_ready,
    input  Y,
    input  grant_valid,
    input  timeout
  );

endinterface : rr_arb4_if

// File: rtl/rr_arb4_pick4.sv
// rr_pick4: combinational round-robin winner selection for four requesters.
// The search starts one past the last-served index and wraps, so the last
// served requester has the lowest priority.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Scan ptr+1, ptr+2, ptr+3, ptr (all modulo 4) and take the first set request.
  always_comb begin
    win     = '0;
    win_idx = ptr;
    w_found = 1'b0;
    w_cand  = ptr;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = ptr + IDX_W'(off);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        win_idx = w_cand;
      end
    end
    if (w_found) win[win_idx] = 1'b1;
  end

endmodule : rr_pick4

// File: rtl/rr_arb4.sv
// rr_arb4: 4-requester round-robin arbiter with a registered one-hot grant.
// Configuration macro: ARB_GRANT_TIMEOUT_EN enables abandoning a grant after
// TIMEOUT unaccepted cycles; without it the grant is held until accepted and
// the timeout output is tied low.
module rr_arb4
  import arb4_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_arb4_if.master       bus,
  output arb_state_t      o_state
);

  // TIMEOUT must fit the 8-bit no-accept counter and allow at least two cycles.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arb4: TIMEOUT out of range 2..255");
  end

  arb_state_t       r_state,   w_state_nxt;
  logic [IDX_W-1:0] r_ptr,     w_ptr_nxt;
  logic [IDX_W-1:0] r_gidx,    w_gidx_nxt;
  logic [N_REQ-1:0] r_y,       w_y_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [N_REQ-1:0] w_win;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_load;

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
`endif

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  // Next-state and next-output logic; everything holds unless a case changes it.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gidx_nxt    = r_gidx;
    w_y_nxt       = r_y;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_load        = 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        w_load = |bus.req;
      end
      // The GAP cycle itself is the zero cycle; its closing edge runs the IDLE
      // arbitration directly so back-to-back grants are separated by exactly one
      // zero cycle.
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
        w_load      = |bus.req;
      end
      ST_GRANT: begin
        if (r_valid && bus.grant_ready) begin
          w_ptr_nxt   = r_gidx;
          w_y_nxt     = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_GAP;
        end
`ifdef ARB_GRANT_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_ptr_nxt     = r_gidx;
          w_y_nxt       = '0;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_y_nxt     = '0;
        w_valid_nxt = 1'b0;
      end
    endcase

    if (w_load) begin
      w_y_nxt     = w_win;
      w_valid_nxt = 1'b1;
      w_gidx_nxt  = w_win_idx;
      w_state_nxt = ST_GRANT;
`ifdef ARB_GRANT_TIMEOUT_EN
      w_cnt_nxt   = 8'd0;
`endif
    end
  end

  // State and output registers; reset drops any pending grant silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PTR_RST;
      r_gidx    <= '0;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_y       <= w_y_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

`ifdef ARB_GRANT_TIMEOUT_EN
  // Count of GRANT cycles that ended without an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= 8'd0;
    else     r_cnt <= w_cnt_nxt;
  end
`endif

  assign bus.Y           = r_y;
  assign bus.grant_valid = r_valid;
  assign bus.timeout     = r_timeout;
  assign o_state         = r_state;

endmodule : rr_arb4

// File: tb/tb_rr_arb4.sv
// Directed testbench for rr_arb4: a table of per-cycle vectors plus hand-written
// sequences for grant hold, timeout/long hold and asynchronous reset mid-grant.
module tb_rr_arb4;
  import arb4_pkg::*;

  logic       clk;
  logic       rst;
  arb_state_t w_state;
  int         checks;
  int         errors;

  rr_arb4_if bus ();

  rr_arb4 #(.TIMEOUT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (w_state)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] y;
    logic       v;
    logic       to;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [0:NV-1];

  task automatic check(input string nm, input logic [3:0] y, input logic v, input logic to);
    checks++;
    if (bus.Y !== y || bus.grant_valid !== v || bus.timeout !== to) begin
      errors++;
      $display("FAIL %s: got Y=%b valid=%b timeout=%b, expected Y=%b valid=%b timeout=%b",
               nm, bus.Y, bus.grant_valid, bus.timeout, y, v, to);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    bus.req = 4'b0000;
    bus.grant_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_outputs", 4'b0000, 1'b0, 1'b0);
    checks++;
    if (w_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", w_state, ST_IDLE);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req = 4'b0000;
    bus.grant_ready = 1'b0;

    // Single requester: grant, one zero cycle, re-grant; ready while idle is ignored.
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    // All requesting with ready held high: full rotation and wrap back to 0.
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
    // Grant held while stalled even though req changes; then accept and move on.
    tbl[13] = '{1'b1, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0};
    // Requester 3 served, then 0 wins over 3 (pointer wrap).
    tbl[20] = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].do_rst) do_reset();
      bus.req = tbl[i].req;
      bus.grant_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d", i), tbl[i].y, tbl[i].v, tbl[i].to);
    end

    // Reset pulsed between edges mid-grant: grant dropped at once, no timeout pulse.
    do_reset();
    bus.req = 4'b1001;
    bus.grant_ready = 1'b0;
    tick();
    check("midrst_grant", 4'b0001, 1'b1, 1'b0);
    tick();
    check("midrst_hold", 4'b0001, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check("midrst_async", 4'b0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    check("midrst_regrant", 4'b0001, 1'b1, 1'b0);

`ifdef ARB_GRANT_TIMEOUT_EN
    // Stalled grant abandoned after exactly 8 valid cycles.
    do_reset();
    bus.req = 4'b0010;
    bus.grant_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("to_hold%0d", c), 4'b0010, 1'b1, 1'b0);
    end
    tick();
    check("to_pulse", 4'b0000, 1'b0, 1'b1);
    tick();
    check("to_regrant", 4'b0010, 1'b1, 1'b0);
    // Accept in the final allowed cycle wins over the timeout.
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("to_hold2_%0d", c), 4'b0010, 1'b1, 1'b0);
    end
    bus.grant_ready = 1'b1;
    tick();
    check("to_accept_last", 4'b0000, 1'b0, 1'b0);
`else
    // Without the timeout feature a stalled grant is held indefinitely.
    do_reset();
    bus.req = 4'b0010;
    bus.grant_ready = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      tick();
      check($sformatf("hold%0d", c), 4'b0010, 1'b1, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb4
